// File: rtl/sw_cond_pkg.sv
// Shared definitions for the switch-conditioning blocks.
// - sw_state_t and the S_* constants: 2-bit debounce FSM encoding.
// - CLK_HZ, DEBOUNCE_MS, LONG_PRESS_MS: default board timing.
// - ms_to_cycles(): converts a millisecond interval into i_Clk cycles.
package sw_cond_pkg;

  typedef logic [1:0] sw_state_t;

  localparam sw_state_t S_LOW      = 2'd0;
  localparam sw_state_t S_RISE_CHK = 2'd1;
  localparam sw_state_t S_HIGH     = 2'd2;
  localparam sw_state_t S_FALL_CHK = 2'd3;

  localparam int unsigned CLK_HZ        = 25000000;
  localparam int unsigned DEBOUNCE_MS   = 10;
  localparam int unsigned LONG_PRESS_MS = 1000;

  function automatic int unsigned ms_to_cycles(input int unsigned ms);
    return (CLK_HZ / 1000) * ms;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser with synchronous active-high reset.
// Ports:
//   clk - destination clock
//   rst - synchronous, active-high reset; clears both stages
//   d   - asynchronous input bus (each bit synchronised independently)
//   q   - synchronised output, two clk edges behind d
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= d;
      sync2 <= sync1;
    end
  end

  assign q = sync2;

endmodule

// File: rtl/switch_debounce_sync.sv
// Push-button conditioning: synchronise, debounce, and emit a clean level with
// single-cycle press/release strobes.
// Ports:
//   i_Clk        - system clock, all logic on its rising edge
//   i_Reset      - synchronous, active-high reset
//   i_Switch     - raw asynchronous switch level (1 = pressed)
//   o_Switch     - debounced level
//   o_Press      - one-cycle strobe on the debounced 0->1 change
//   o_Release    - one-cycle strobe on the debounced 1->0 change
//   o_Long_Press - one-cycle strobe after the level has been high for
//                  LONG_PRESS_LIMIT cycles
// Build option: define LONG_PRESS_EN to build the hold counter; otherwise
// o_Long_Press is tied to 0.
module switch_debounce_sync
  import sw_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_LIMIT   = ms_to_cycles(DEBOUNCE_MS),
  parameter int unsigned LONG_PRESS_LIMIT = ms_to_cycles(LONG_PRESS_MS)
) (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_Switch,
  output logic o_Switch,
  output logic o_Press,
  output logic o_Release,
  output logic o_Long_Press
);

  if (DEBOUNCE_LIMIT < 2) begin : g_bad_debounce_limit
    $error("DEBOUNCE_LIMIT must be >= 2");
  end
  if (LONG_PRESS_LIMIT < 2) begin : g_bad_long_press_limit
    $error("LONG_PRESS_LIMIT must be > 1");
  end

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);

  logic             sw_sync;
  sw_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             switch_q, switch_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

  sync_2ff #(
    .WIDTH(1)
  ) u_sync (
    .clk(i_Clk),
    .rst(i_Reset),
    .d  (i_Switch),
    .q  (sw_sync)
  );

  // The counter is cleared on every transition so it can never wrap.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      S_LOW: begin
        cnt_d = '0;
        if (sw_sync) begin
          state_d = S_RISE_CHK;
          cnt_d   = CNT_W'(1);
        end
      end
      S_RISE_CHK: begin
        if (!sw_sync) begin
          state_d = S_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_HIGH;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HIGH: begin
        cnt_d = '0;
        if (!sw_sync) begin
          state_d = S_FALL_CHK;
          cnt_d   = CNT_W'(1);
        end
      end
      S_FALL_CHK: begin
        if (sw_sync) begin
          state_d = S_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = S_LOW;
          cnt_d     = '0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_LOW;
        cnt_d   = '0;
      end
    endcase
    // Level follows the next state so it changes in the same cycle as the strobe.
    switch_d = (state_d == S_HIGH) || (state_d == S_FALL_CHK);
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q   <= S_LOW;
      cnt_q     <= '0;
      switch_q  <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      switch_q  <= switch_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign o_Switch  = switch_q;
  assign o_Press   = press_q;
  assign o_Release = release_q;

`ifdef LONG_PRESS_EN
  localparam int unsigned HOLD_W = $clog2(LONG_PRESS_LIMIT + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_LIMIT - 1);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              long_q, long_d;

  // Cleared only on a fresh press, so a rejected fall bounce keeps counting.
  // Saturates at HOLD_LAST, which limits the strobe to once per press.
  always_comb begin
    hold_d = hold_q;
    long_d = 1'b0;
    if (state_q == S_LOW || (state_q == S_RISE_CHK && state_d == S_HIGH)) begin
      hold_d = '0;
    end else if (state_q == S_HIGH || state_q == S_FALL_CHK) begin
      if (hold_q != HOLD_LAST) begin
        hold_d = hold_q + 1'b1;
        long_d = (hold_d == HOLD_LAST);
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  assign o_Long_Press = long_q;
`else
  assign o_Long_Press = 1'b0;
`endif

endmodule

// File: tb/tb_switch_debounce_sync.sv
// Self-checking bench for switch_debounce_sync with DEBOUNCE_LIMIT=4 and
// LONG_PRESS_LIMIT=10. Each scenario pushes its expected per-cycle outputs
// {o_Switch, o_Press, o_Release, o_Long_Press} into a queue, then drives the
// stimulus and pops one entry per clock. Scenarios run back to back, so each
// one starts from the state the previous one left behind.
module tb_switch_debounce_sync;

`ifdef LONG_PRESS_EN
  localparam bit LP = 1'b1;
`else
  localparam bit LP = 1'b0;
`endif

  logic i_Clk;
  logic i_Reset;
  logic i_Switch;
  logic o_Switch;
  logic o_Press;
  logic o_Release;
  logic o_Long_Press;

  logic [3:0] obs;
  logic [3:0] exp_q[$];
  logic [3:0] e;
  int         errors;
  int         checks;

  assign obs = {o_Switch, o_Press, o_Release, o_Long_Press};

  switch_debounce_sync #(
    .DEBOUNCE_LIMIT  (4),
    .LONG_PRESS_LIMIT(10)
  ) dut (
    .i_Clk       (i_Clk),
    .i_Reset     (i_Reset),
    .i_Switch    (i_Switch),
    .o_Switch    (o_Switch),
    .o_Press     (o_Press),
    .o_Release   (o_Release),
    .o_Long_Press(o_Long_Press)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  // Reset held 3 cycles then 20 idle cycles: everything stays 0.
  task automatic test_reset();
    for (int k = 1; k <= 23; k++) exp_q.push_back(4'b0000);
    for (int k = 1; k <= 23; k++) begin
      i_Reset  = (k <= 3);
      i_Switch = 1'b0;
      @(posedge i_Clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL reset k=%0d got=%b want=%b", k, obs, e);
      end
    end
  endtask

  // Clean 0->1 step: level and press strobe appear on the 6th edge.
  task automatic test_press();
    for (int k = 1; k <= 7; k++) exp_q.push_back({k >= 6, k == 6, 1'b0, 1'b0});
    for (int k = 1; k <= 7; k++) begin
      i_Reset  = 1'b0;
      i_Switch = 1'b1;
      @(posedge i_Clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL press k=%0d got=%b want=%b", k, obs, e);
      end
    end
  endtask

  // Clean 1->0 step: level drops with the release strobe on the 6th edge.
  task automatic test_release();
    for (int k = 1; k <= 8; k++) exp_q.push_back({k <= 5, 1'b0, k == 6, 1'b0});
    for (int k = 1; k <= 8; k++) begin
      i_Reset  = 1'b0;
      i_Switch = 1'b0;
      @(posedge i_Clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL release k=%0d got=%b want=%b", k, obs, e);
      end
    end
  endtask

  // High 3, low 1, high 3, low 1: rejected. Then high 6: one press at edge 14.
  task automatic test_bounce();
    logic [13:0] pat;
    pat = 14'b11_1111_0111_0111;
    for (int k = 1; k <= 14; k++) exp_q.push_back({k >= 14, k == 14, 1'b0, 1'b0});
    for (int k = 1; k <= 14; k++) begin
      i_Reset  = 1'b0;
      i_Switch = pat[k-1];
      @(posedge i_Clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL bounce k=%0d got=%b want=%b", k, obs, e);
      end
    end
  endtask

  // 2-cycle low glitch while high: level stays 1, no strobes.
  task automatic test_glitch_high();
    for (int k = 1; k <= 8; k++) exp_q.push_back(4'b1000);
    for (int k = 1; k <= 8; k++) begin
      i_Reset  = 1'b0;
      i_Switch = (k >= 3);
      @(posedge i_Clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL glitch_high k=%0d got=%b want=%b", k, obs, e);
      end
    end
  endtask

  // Fall check reaches count 2, reset hits with input high again: level drops
  // without a release, then a press fires 6 edges after reset release. The
  // hold count carried in from the glitch scenario expires on edge 1.
  task automatic test_reset_mid_fall();
    for (int k = 1; k <= 12; k++)
      exp_q.push_back({(k <= 4) || (k >= 11), k == 11, 1'b0, LP && (k == 1)});
    for (int k = 1; k <= 12; k++) begin
      i_Reset  = (k == 5);
      i_Switch = (k >= 3);
      @(posedge i_Clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL reset_mid_fall k=%0d got=%b want=%b", k, obs, e);
      end
    end
  endtask

  // Long hold: single long-press strobe 9 edges after the press, then none.
  task automatic test_long_press();
    for (int k = 1; k <= 20; k++) exp_q.push_back({1'b1, 1'b0, 1'b0, LP && (k == 8)});
    for (int k = 1; k <= 20; k++) begin
      i_Reset  = 1'b0;
      i_Switch = 1'b1;
      @(posedge i_Clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL long_press k=%0d got=%b want=%b", k, obs, e);
      end
    end
  endtask

  // Release after the long hold: exactly one release, no extra long-press.
  task automatic test_back_to_back();
    for (int k = 1; k <= 8; k++) exp_q.push_back({k <= 5, 1'b0, k == 6, 1'b0});
    for (int k = 1; k <= 8; k++) begin
      i_Reset  = 1'b0;
      i_Switch = 1'b0;
      @(posedge i_Clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL back_to_back k=%0d got=%b want=%b", k, obs, e);
      end
    end
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    i_Reset  = 1'b1;
    i_Switch = 1'b0;
    test_reset();
    test_press();
    test_release();
    test_bounce();
    test_glitch_high();
    test_reset_mid_fall();
    test_long_press();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
